// File: rtl/rx_frame_capture_if.sv
// Capture-side bundle: level-style byte input, readout valid/ready stream and status.
// The slave modport is the capture block; the master modport drives it.
interface rx_frame_capture_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              rd_start;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              frame_done;
    logic              busy;
    logic [ADDR_W:0]   byte_count;
    logic              timeout_flag;
    logic              overflow;

    modport master (
        output in_data, in_valid, rd_start, out_ready,
        input  out_data, out_valid, frame_done, busy, byte_count, timeout_flag, overflow
    );

    modport slave (
        input  in_data, in_valid, rd_start, out_ready,
        output out_data, out_valid, frame_done, busy, byte_count, timeout_flag, overflow
    );
endinterface

// File: rtl/rx_frame_capture.sv
// Captures one word per in_valid rising edge into a DEPTH-word buffer, builds FRAME_LEN-word frames.
// Readout: first word 2 cycles after rd_start, then 1 word/cycle; out_data holds while out_ready is low.
module rx_frame_capture #(
    parameter  int DATA_W      = 8,
    parameter  int DEPTH       = 1024,
    parameter  int FRAME_LEN   = 121,
    parameter  int TIMEOUT_CYC = 50000,
    localparam int ADDR_W      = $clog2(DEPTH)
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    rx_frame_capture_if.slave  rx
);
    localparam int CNT_W  = ADDR_W + 1;
    localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [CNT_W-1:0]  FRAME_LEN_C = CNT_W'(FRAME_LEN);
    localparam logic [IDLE_W-1:0] IDLE_LAST_C = IDLE_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        READY   = 2'd2,
        READOUT = 2'd3
    } state_t;

    state_t              state_q,      state_d;
    logic                in_valid_q,   in_valid_d;
    logic [ADDR_W-1:0]   wr_ptr_q,     wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr_q,     rd_ptr_d;
    logic [CNT_W-1:0]    rd_cnt_q,     rd_cnt_d;
    logic [CNT_W-1:0]    byte_count_q, byte_count_d;
    logic [IDLE_W-1:0]   idle_cnt_q,   idle_cnt_d;
    logic                out_valid_q,  out_valid_d;
    logic                frame_done_q, frame_done_d;
    logic                busy_q,       busy_d;
    logic                timeout_q,    timeout_d;
    logic                overflow_q,   overflow_d;
    logic [DATA_W-1:0]   out_data_q;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic                acc;
    logic                hs;
    logic                load;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic                rd_en;
    logic [CNT_W-1:0]    next_count;

    assign acc        = rx.in_valid & ~in_valid_q;
    assign hs         = out_valid_q & rx.out_ready;
    assign next_count = byte_count_q + CNT_W'(1);

    // Refill the output register whenever it is empty or being drained, until the frame is exhausted.
    assign load = (~out_valid_q | rx.out_ready) & (rd_cnt_q != FRAME_LEN_C);

    always_comb begin
        state_d      = state_q;
        in_valid_d   = rx.in_valid;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        rd_cnt_d     = rd_cnt_q;
        byte_count_d = byte_count_q;
        idle_cnt_d   = idle_cnt_q;
        out_valid_d  = out_valid_q;
        timeout_d    = 1'b0;
        overflow_d   = overflow_q;
        wr_en        = 1'b0;
        wr_addr      = wr_ptr_q;
        rd_en        = 1'b0;

        case (state_q)
            IDLE: begin
                if (acc) begin
                    wr_en        = 1'b1;
                    wr_addr      = '0;
                    wr_ptr_d     = ADDR_W'(1);
                    byte_count_d = CNT_W'(1);
                    idle_cnt_d   = '0;
                    state_d      = (FRAME_LEN == 1) ? READY : CAPTURE;
                end
            end
            CAPTURE: begin
                if (acc) begin
                    wr_en        = 1'b1;
                    wr_ptr_d     = wr_ptr_q + ADDR_W'(1);
                    byte_count_d = next_count;
                    idle_cnt_d   = '0;
                    if (next_count == FRAME_LEN_C) begin
                        state_d = READY;
                    end
                end else if (idle_cnt_q == IDLE_LAST_C) begin
                    timeout_d    = 1'b1;
                    byte_count_d = '0;
                    idle_cnt_d   = '0;
                    state_d      = IDLE;
                end else begin
                    idle_cnt_d = idle_cnt_q + IDLE_W'(1);
                end
            end
            READY: begin
                if (acc) begin
                    overflow_d = 1'b1;
                end
                if (rx.rd_start) begin
                    rd_ptr_d = '0;
                    rd_cnt_d = '0;
                    state_d  = READOUT;
                end
            end
            READOUT: begin
                if (acc) begin
                    overflow_d = 1'b1;
                end
                if (load) begin
                    rd_en       = 1'b1;
                    rd_ptr_d    = rd_ptr_q + ADDR_W'(1);
                    rd_cnt_d    = rd_cnt_q + CNT_W'(1);
                    out_valid_d = 1'b1;
                end else if (hs) begin
                    // Nothing left to load, so this handshake retired the last word.
                    out_valid_d  = 1'b0;
                    byte_count_d = '0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        frame_done_d = (state_d == READY);
        busy_d       = (state_d == CAPTURE) || (state_d == READOUT);
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q      <= IDLE;
            in_valid_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            rd_cnt_q     <= '0;
            byte_count_q <= '0;
            idle_cnt_q   <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
            timeout_q    <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            in_valid_q   <= in_valid_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            rd_cnt_q     <= rd_cnt_d;
            byte_count_q <= byte_count_d;
            idle_cnt_q   <= idle_cnt_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
            timeout_q    <= timeout_d;
            overflow_q   <= overflow_d;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (wr_en && !reset) begin
            mem[wr_addr] <= rx.in_data;
        end
    end

    // Synchronous read straight into the output register keeps the RAM inferable.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            out_data_q <= '0;
        end else if (rd_en) begin
            out_data_q <= mem[rd_ptr_q];
        end
    end

    assign rx.out_data     = out_data_q;
    assign rx.out_valid    = out_valid_q;
    assign rx.frame_done   = frame_done_q;
    assign rx.busy         = busy_q;
    assign rx.byte_count   = byte_count_q;
    assign rx.timeout_flag = timeout_q;
    assign rx.overflow     = overflow_q;
endmodule

// File: tb/tb_rx_frame_capture.sv
// Directed bench: dut_a (FRAME_LEN=4, TIMEOUT_CYC=16) and dut_b (FRAME_LEN=8, TIMEOUT_CYC=64)
// share the same stimulus; each scenario checks whichever instance exercises the case.
module tb_rx_frame_capture;
    logic clk;
    logic rst;

    int n_vec = 0;
    int n_err = 0;

    rx_frame_capture_if #(.DATA_W(8), .ADDR_W(3)) if_a ();
    rx_frame_capture_if #(.DATA_W(8), .ADDR_W(4)) if_b ();

    rx_frame_capture #(.DATA_W(8), .DEPTH(8), .FRAME_LEN(4), .TIMEOUT_CYC(16)) dut_a (
        .CLOCK_50 (clk),
        .reset    (rst),
        .rx       (if_a.slave)
    );

    rx_frame_capture #(.DATA_W(8), .DEPTH(16), .FRAME_LEN(8), .TIMEOUT_CYC(64)) dut_b (
        .CLOCK_50 (clk),
        .reset    (rst),
        .rx       (if_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [7:0] d);
        if_a.in_valid = v;
        if_b.in_valid = v;
        if_a.in_data  = d;
        if_b.in_data  = d;
    endtask

    task automatic set_rd(input logic s);
        if_a.rd_start = s;
        if_b.rd_start = s;
    endtask

    task automatic set_ready(input logic r);
        if_a.out_ready = r;
        if_b.out_ready = r;
    endtask

    task automatic pulse(input logic [7:0] d);
        set_in(1'b1, d);
        tick();
        set_in(1'b0, d);
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_in(1'b0, 8'h00);
        set_rd(1'b0);
        set_ready(1'b1);
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Readout with out_ready held high; the first word is two edges after rd_start.
    task automatic read_frame_a(input logic [7:0] w0, input logic [7:0] w1,
                                input logic [7:0] w2, input logic [7:0] w3, input string tag);
        logic [7:0] exp [4];
        exp[0] = w0; exp[1] = w1; exp[2] = w2; exp[3] = w3;
        set_ready(1'b1);
        set_rd(1'b1);
        tick();
        set_rd(1'b0);
        chk({tag, "_fd_fall"}, if_a.frame_done, 0);
        chk({tag, "_busy_ro"}, if_a.busy, 1);
        chk({tag, "_no_early_vld"}, if_a.out_valid, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk({tag, "_vld"}, if_a.out_valid, 1);
            chk({tag, "_dat"}, if_a.out_data, exp[i]);
        end
        tick();
        chk({tag, "_vld_end"}, if_a.out_valid, 0);
        chk({tag, "_busy_end"}, if_a.busy, 0);
        chk({tag, "_bc_end"}, if_a.byte_count, 0);
    endtask

    initial begin
        logic [7:0] bp_exp [4];
        int         got;
        int         cyc;
        logic       rdy;
        logic       prev_stall;
        logic [7:0] prev_dat;

        rst = 1'b1;
        set_in(1'b0, 8'h00);
        set_rd(1'b0);
        set_ready(1'b0);

        // Reset held three cycles: every output low.
        tick(); tick(); tick();
        chk("rst_vld",  if_a.out_valid, 0);
        chk("rst_dat",  if_a.out_data, 0);
        chk("rst_fd",   if_a.frame_done, 0);
        chk("rst_busy", if_a.busy, 0);
        chk("rst_bc",   if_a.byte_count, 0);
        chk("rst_to",   if_a.timeout_flag, 0);
        chk("rst_ovf",  if_a.overflow, 0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) pulse(8'h10 + 8'(i));
        chk("five_bc_b",   if_b.byte_count, 5);
        chk("five_busy_b", if_b.busy, 1);
        chk("five_bc_a",   if_a.byte_count, 4);
        chk("five_ovf_a",  if_a.overflow, 1);

        // Four-word frame, then a back-to-back readout.
        do_reset();
        pulse(8'hA1); pulse(8'hA2); pulse(8'hA3);
        chk("fr_fd_early", if_a.frame_done, 0);
        set_in(1'b1, 8'hA4);
        tick();
        set_in(1'b0, 8'hA4);
        chk("fr_fd",   if_a.frame_done, 1);
        chk("fr_bc",   if_a.byte_count, 4);
        chk("fr_busy", if_a.busy, 0);
        read_frame_a(8'hA1, 8'hA2, 8'hA3, 8'hA4, "fr");
        chk("fr_ovf", if_a.overflow, 0);

        // A level held high counts as a single word.
        do_reset();
        set_in(1'b1, 8'h55);
        for (int i = 0; i < 20; i++) tick();
        chk("hold_bc_b", if_b.byte_count, 1);
        chk("hold_bc_a", if_a.byte_count, 0);
        set_in(1'b0, 8'h55);
        tick();

        // Backpressure: out_ready alternates, each word once, data stable while stalled.
        do_reset();
        bp_exp[0] = 8'hB1; bp_exp[1] = 8'hB2; bp_exp[2] = 8'hB3; bp_exp[3] = 8'hB4;
        for (int i = 0; i < 4; i++) pulse(bp_exp[i]);
        set_rd(1'b1);
        tick();
        set_rd(1'b0);
        got = 0;
        cyc = 0;
        prev_stall = 1'b0;
        prev_dat = 8'h00;
        while (got < 4 && cyc < 40) begin
            rdy = cyc[0];
            set_ready(rdy);
            if (prev_stall) begin
                chk("bp_hold_vld", if_a.out_valid, 1);
                chk("bp_hold_dat", if_a.out_data, prev_dat);
            end
            if (if_a.out_valid && rdy) begin
                chk("bp_word", if_a.out_data, bp_exp[got]);
                got++;
            end
            prev_stall = if_a.out_valid && !rdy;
            prev_dat   = if_a.out_data;
            tick();
            cyc++;
        end
        chk("bp_count", got, 4);
        chk("bp_vld_end", if_a.out_valid, 0);
        chk("bp_busy_end", if_a.busy, 0);
        set_ready(1'b1);

        // Idle timeout after two words; the next frame restarts at address 0.
        do_reset();
        pulse(8'h21); pulse(8'h22);
        for (int i = 0; i < 14; i++) tick();
        chk("to_not_yet", if_a.timeout_flag, 0);
        chk("to_bc_pre",  if_a.byte_count, 2);
        tick();
        chk("to_pulse",   if_a.timeout_flag, 1);
        chk("to_bc",      if_a.byte_count, 0);
        chk("to_busy",    if_a.busy, 0);
        tick();
        chk("to_one_shot", if_a.timeout_flag, 0);
        set_rd(1'b1);
        tick();
        set_rd(1'b0);
        chk("rd_idle_ignored", if_a.busy, 0);
        pulse(8'h31); pulse(8'h32); pulse(8'h33); pulse(8'h34);
        chk("to_fd", if_a.frame_done, 1);
        read_frame_a(8'h31, 8'h32, 8'h33, 8'h34, "to");

        // Word arriving in READY is dropped; reset during readout.
        do_reset();
        pulse(8'hC1); pulse(8'hC2); pulse(8'hC3); pulse(8'hC4);
        pulse(8'hEE);
        chk("ov_flag", if_a.overflow, 1);
        chk("ov_bc",   if_a.byte_count, 4);
        chk("ov_fd",   if_a.frame_done, 1);
        set_ready(1'b1);
        set_rd(1'b1);
        tick();
        set_rd(1'b0);
        tick();
        chk("ov_d0", if_a.out_data, 8'hC1);
        tick();
        chk("ov_d1", if_a.out_data, 8'hC2);
        tick();
        chk("ov_d2", if_a.out_data, 8'hC3);
        chk("ov_sticky", if_a.overflow, 1);
        rst = 1'b1;
        tick();
        chk("mrst_vld",  if_a.out_valid, 0);
        chk("mrst_busy", if_a.busy, 0);
        chk("mrst_fd",   if_a.frame_done, 0);
        chk("mrst_ovf",  if_a.overflow, 0);
        chk("mrst_bc",   if_a.byte_count, 0);
        rst = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
